// File: rtl/mmio_pkg.sv
// Shared memory-map definitions for the store steering logic and the read mux:
// region codes, MMIO register offsets, store size encodings and lane helpers.
package mmio_pkg;

  // Region codes decoded from addr[31:28]
  localparam logic [3:0] REG_DMEM = 4'b0001;
  localparam logic [3:0] REG_IMEM = 4'b0010;
  localparam logic [3:0] REG_BOTH = 4'b0011;
  localparam logic [3:0] REG_BIOS = 4'b0100;
  localparam logic [3:0] REG_MMIO = 4'b1000;

  // MMIO register byte offsets within the MMIO region
  localparam logic [7:0] UART_CTRL = 8'h00;
  localparam logic [7:0] UART_RX   = 8'h04;
  localparam logic [7:0] UART_TX   = 8'h08;
  localparam logic [7:0] CYC       = 8'h10;
  localparam logic [7:0] INST      = 8'h14;
  localparam logic [7:0] CNT_RST   = 8'h18;

  // Word index (addr[5:2]) of the MMIO registers that stores act on
  localparam logic [3:0] IDX_UART_TX = UART_TX[5:2];
  localparam logic [3:0] IDX_CNT_RST = CNT_RST[5:2];

  // Store size encodings
  typedef enum logic [1:0] {
    SZ_B    = 2'b00,
    SZ_H    = 2'b01,
    SZ_W    = 2'b10,
    SZ_NONE = 2'b11
  } size_e;

  // Byte enables of a store before region gating
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lo;
      SZ_H:    be = 4'b0011 << {lo[1], 1'b0};
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated so every enabled lane sees the right bytes
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      SZ_W:    r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  // A half must be 2-byte aligned and a word 4-byte aligned
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic m;
    case (sz)
      SZ_H:    m = lo[0];
      SZ_W:    m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mmio_tx_hold.sv
// Single-entry UART transmit holding register with valid/ready handshake and a
// sticky overflow flag for bytes written while the entry is still occupied.
module mmio_tx_hold
  import mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] wr_byte,
  input  logic       trmt_ready,
  output logic [7:0] trmt_data,
  output logic       trmt_valid,
  output logic       trmt_full,
  output logic       tx_overflow
);

  logic       full_d, full_q;
  logic [7:0] data_d, data_q;
  logic       ovf_d,  ovf_q;

  // Next-state: free on handshake; a write lands only if the entry was empty at
  // the start of the cycle, otherwise it is dropped and flagged.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (full_q && trmt_ready) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (wr) begin
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        full_d = 1'b1;
        data_d = wr_byte;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Holding register state; reset discards any pending byte immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign trmt_data   = data_q;
  assign trmt_valid  = full_q;
  assign trmt_full   = full_q;
  assign tx_overflow = ovf_q;

endmodule

// File: rtl/dmem_wsel.sv
// Store-side steering for the memory stage: decodes each store into DMEM/IMEM
// byte enables with lane-aligned data, the UART transmit holding register and
// the counter reset, and owns the cycle / retired-instruction counters.
module dmem_wsel
  import mmio_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             wr_en,
  input  logic [1:0]       size,
  input  logic             inst_retire,
  output logic [3:0]       dmem_wea,
  output logic [31:0]      dmem_dina,
  output logic [3:0]       imem_wea,
  output logic [7:0]       trmt_data,
  output logic             trmt_valid,
  input  logic             trmt_ready,
  output logic             trmt_full,
  output logic             tx_overflow,
  output logic             misalign,
  output logic [CNT_W-1:0] counter_cycle,
  output logic [CNT_W-1:0] counter_inst
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             dmem_hit_s, imem_hit_s, mmio_hit_s;
  logic             store_ok_s, mis_s, go_s;
  logic [3:0]       be_s;
  logic             tx_wr_s, cnt_rst_s;
  logic             misalign_d, misalign_q;
  logic [CNT_W-1:0] cyc_d, cyc_q;
  logic [CNT_W-1:0] inst_d, inst_q;
  logic             unused_addr_s;

  assign unused_addr_s = ^addr[27:6];

  // Region decode and misalignment qualification of the current store
  always_comb begin
    dmem_hit_s = 1'b0;
    imem_hit_s = 1'b0;
    mmio_hit_s = 1'b0;
    case (addr[31:28])
      REG_DMEM: dmem_hit_s = 1'b1;
      REG_IMEM: imem_hit_s = 1'b1;
      REG_BOTH: begin
        dmem_hit_s = 1'b1;
        imem_hit_s = 1'b1;
      end
      REG_MMIO: mmio_hit_s = 1'b1;
      default: begin
        dmem_hit_s = 1'b0;
        imem_hit_s = 1'b0;
        mmio_hit_s = 1'b0;
      end
    endcase
    store_ok_s = wr_en && (size != SZ_NONE);
    mis_s      = is_misaligned(size, addr[1:0]);
    go_s       = store_ok_s && !mis_s;
    be_s       = lane_be(size, addr[1:0]);
  end

  // Same-cycle memory enables and lane data; the BRAM writes on this edge
  always_comb begin
    dmem_dina = lane_data(size, wdata);
    if (go_s && dmem_hit_s) begin
      dmem_wea = be_s;
    end else begin
      dmem_wea = 4'b0000;
    end
    if (go_s && imem_hit_s) begin
      imem_wea = be_s;
    end else begin
      imem_wea = 4'b0000;
    end
  end

  // MMIO register selection on the word index; size does not matter here
  always_comb begin
    tx_wr_s   = 1'b0;
    cnt_rst_s = 1'b0;
    if (go_s && mmio_hit_s) begin
      case (addr[5:2])
        IDX_UART_TX: tx_wr_s   = 1'b1;
        IDX_CNT_RST: cnt_rst_s = 1'b1;
        default: begin
          tx_wr_s   = 1'b0;
          cnt_rst_s = 1'b0;
        end
      endcase
    end else begin
      tx_wr_s   = 1'b0;
      cnt_rst_s = 1'b0;
    end
  end

  // Misalign pulse and counter next state; the counter reset beats increments
  always_comb begin
    misalign_d = store_ok_s && mis_s && (dmem_hit_s || imem_hit_s || mmio_hit_s);
    cyc_d      = cyc_q + CNT_ONE;
    inst_d     = inst_q;
    if (cnt_rst_s) begin
      cyc_d  = '0;
      inst_d = '0;
    end else if (inst_retire) begin
      inst_d = inst_q + CNT_ONE;
    end else begin
      inst_d = inst_q;
    end
  end

  // Counter and misalign registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      cyc_q      <= '0;
      inst_q     <= '0;
    end else begin
      misalign_q <= misalign_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
    end
  end

  assign misalign      = misalign_q;
  assign counter_cycle = cyc_q;
  assign counter_inst  = inst_q;

  mmio_tx_hold u_tx_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (tx_wr_s),
    .wr_byte     (wdata[7:0]),
    .trmt_ready  (trmt_ready),
    .trmt_data   (trmt_data),
    .trmt_valid  (trmt_valid),
    .trmt_full   (trmt_full),
    .tx_overflow (tx_overflow)
  );

endmodule

// File: doc/dmem_wsel.md
Name: dmem_wsel

Overview:
- Store-side counterpart of the core's memory-mapped read mux.
- Decodes each store issued by the memory stage and steers it to:
  - DMEM and/or IMEM write ports, with byte enables and data lane alignment;
  - a one-entry UART transmit holding register;
  - the cycle and instruction counter reset.
- Owns the cycle and instruction counters and the transmit-full status that the read mux returns.

Parameters:
- CNT_W, 32, width of the cycle and instruction counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  32  store byte address.
- wdata  input  32  store data from rs2, unaligned in bits [7:0]/[15:0].
- wr_en  input  1  store valid this cycle.
- size  input  2  00 = byte, 01 = half, 10 = word; 11 is treated as no store.
- inst_retire  input  1  one instruction retires this cycle.
- dmem_wea  output  4  DMEM byte write enables.
- dmem_dina  output  32  lane-aligned DMEM/IMEM write data.
- imem_wea  output  4  IMEM byte write enables.
- trmt_data  output  8  byte presented to the UART transmitter.
- trmt_valid  output  1  trmt_data is valid.
- trmt_ready  input  1  UART accepts trmt_data this cycle.
- trmt_full  output  1  holding register occupied; read back as ~bit0 of the status word.
- tx_overflow  output  1  sticky: a transmit write was dropped.
- misalign  output  1  one-cycle pulse when a store is misaligned.
- counter_cycle  output  CNT_W  cycle counter.
- counter_inst  output  CNT_W  retired-instruction counter.

Behaviour:
- Reset (async, rst_n=0):
  - trmt_valid=0, trmt_full=0, trmt_data=0, tx_overflow=0, misalign=0, both counters=0.
  - dmem_wea and imem_wea are combinational and read 0 while wr_en=0.
- Region decode on addr[31:28]:
  - 0001 → DMEM.
  - 0010 → IMEM.
  - 0011 → both DMEM and IMEM.
  - 1000 → MMIO.
  - All other values, including BIOS 0100 → store ignored, no side effect.
- Lane alignment:
  - Byte: dmem_dina = wdata[7:0] replicated ×4; enables = 0001 << addr[1:0].
  - Half: dmem_dina = wdata[15:0] replicated ×2; enables = 0011 << (2·addr[1]).
  - Word: dmem_dina = wdata; enables = 1111.
- Misalignment:
  - Half with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - A misaligned store writes nothing, has no MMIO effect, and sets misalign for exactly the next cycle (registered).
- Memory enables are combinational in the same cycle as wr_en; the BRAM performs the write on that clock edge.
- MMIO decode on addr[5:2]; size is ignored and the low byte of wdata is used:
  - 0x80000008 (0010) → transmit write.
  - 0x80000018 (0110) → counter reset.
  - Any other MMIO offset → ignored.
- Transmit holding register (single entry):
  - Write with trmt_full=0: trmt_data ← wdata[7:0]; trmt_valid=trmt_full=1 from the next cycle.
  - trmt_valid & trmt_ready: entry is freed; trmt_valid=0 from the next cycle.
  - Write while full, including the same cycle as a handshake: byte dropped, tx_overflow ← 1. Software must poll status.
  - tx_overflow clears only on reset.
  - trmt_data is held stable while trmt_valid=1.
- Counters:
  - counter_cycle increments by 1 every cycle.
  - counter_inst increments by 1 on cycles where inst_retire=1.
  - Both wrap at 2^CNT_W−1 → 0.
  - A counter-reset store makes both read 0 on the next cycle. The reset takes priority over any increment in that cycle, so an inst_retire in the reset cycle is not counted.
- Reset asserted mid-transfer discards the held byte; trmt_valid drops immediately (async).

Decomposition:
- Shared package mmio_pkg holds:
  - region codes: REG_DMEM=4'b0001, REG_IMEM=4'b0010, REG_BOTH=4'b0011, REG_BIOS=4'b0100, REG_MMIO=4'b1000;
  - MMIO offsets: UART_CTRL 0x00, UART_RX 0x04, UART_TX 0x08, CYC 0x10, INST 0x14, CNT_RST 0x18;
  - size encodings SZ_B, SZ_H, SZ_W.
- The read mux imports the same package.
- One sub-module, mmio_tx_hold, contains the holding register, the valid/ready handshake and tx_overflow.

Test Plan:
- Stores to DMEM:
  - sb addr=0x10000003 wdata=0x000000AB → dmem_wea=1000, dmem_dina=0xABABABAB, imem_wea=0000.
  - sh addr=0x30000002 wdata=0x1234 → dmem_wea=imem_wea=1100, dmem_dina=0x12341234.
- Misaligned and BIOS stores:
  - sw addr=0x10000002 → both enables 0000, misalign=1 for one cycle.
  - sw addr=0x40000000 → no enable asserted, no pulse.
- Transmit handshake:
  - sw addr=0x80000008 wdata=0x41, trmt_ready=0 → next cycle trmt_valid=1, trmt_data=0x41, trmt_full=1.
  - Second write of 0x42 → trmt_data stays 0x41, tx_overflow=1.
  - trmt_ready=1 for one cycle → trmt_valid=0 and trmt_full=0 on the following cycle.
- Counter reset versus increment:
  - Run 100 cycles with inst_retire every other cycle → counter_cycle=100, counter_inst=50.
  - Store to 0x80000018 with inst_retire=1 → both counters 0 next cycle, then 1/0 or 1/1 per retire.
- Counter wrap: force counter_cycle to 0xFFFFFFFF → reads 0x00000000 one cycle later.
- Async reset: assert rst_n=0 mid-cycle while trmt_valid=1 → trmt_valid, trmt_full, tx_overflow and counters go 0 immediately, without waiting for a clk edge.
